// File: rtl/iv_port_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : iv_port_responder_if
// Description : Signal bundle for one IV-bus responder port. Carries the
//               CPU-side IV bus (iv_in/iv_out/iv_oeb, lb_n/rb_n, sc/wc) and
//               the user-side transmit/receive byte handshakes.
//   master : drives iv_in, lb_n, rb_n, sc, wc, tx_ready, rx_data, rx_valid
//   slave  : drives iv_out, iv_oeb, tx_data, tx_valid, rx_ready, selected
// Revision    : 1.0 - initial release
// ============================================================================
interface iv_port_responder_if;
  logic [7:0] iv_in;
  logic [7:0] iv_out;
  logic       iv_oeb;
  logic       lb_n;
  logic       rb_n;
  logic       sc;
  logic       wc;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       selected;

  modport master (
    output iv_in, lb_n, rb_n, sc, wc, tx_ready, rx_data, rx_valid,
    input  iv_out, iv_oeb, tx_data, tx_valid, rx_ready, selected
  );

  modport slave (
    input  iv_in, lb_n, rb_n, sc, wc, tx_ready, rx_data, rx_valid,
    output iv_out, iv_oeb, tx_data, tx_valid, rx_ready, selected
  );
endinterface
`default_nettype wire

// File: rtl/iv_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : iv_port_responder
// Description : Peripheral end of the 8x305 IV bus on one bank. Decodes
//               select (SC), write (WC) and read windows, exposing a data
//               register (tx/rx bytes) and a status register.
// Ports       : clk   - bus clock (CPU x1)
//               reset - synchronous, active-low
//               bus   - iv_port_responder_if.slave (IV bus + user handshakes)
// Parameters  : BANK (0 = lb_n, 1 = rb_n), DATA_ADDR, STAT_ADDR (must differ)
// Revision    : 1.0 - initial release
// ============================================================================
module iv_port_responder #(
  parameter int unsigned BANK      = 0,
  parameter logic [7:0]  DATA_ADDR = 8'h10,
  parameter logic [7:0]  STAT_ADDR = 8'h11
) (
  input  wire logic            clk,
  input  wire logic            reset,
  iv_port_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DATA = 2'd1,
    SEL_STAT = 2'd2
  } sel_t;

  // Bus bytes are inverted and bit-reversed relative to the logical byte;
  // the same transform converts in both directions.
  function automatic logic [7:0] f_conv(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ~v[7-i];
    return r;
  endfunction

  sel_t       r_sel;
  sel_t       w_sel_nxt;
  logic       r_sc_q;
  logic       r_wc_q;
  logic       r_rd_q;
  logic [7:0] r_tx_reg;
  logic       r_tx_valid;
  logic       r_tx_ovr;
  logic [7:0] r_rx_reg;
  logic       r_rx_full;
  logic       r_rx_unf;

  logic       w_ben;
  logic [7:0] w_b;
  logic       w_sc_first;
  logic       w_wr;
  logic       w_rd;
  logic       w_rd_first;
  logic       w_drive;
  logic       w_tx_hs;
  logic       w_rx_acc;
  logic [7:0] w_rd_byte;

  assign w_ben      = (BANK != 0) ? ~bus.rb_n : ~bus.lb_n;
  assign w_b        = f_conv(bus.iv_in);
  assign w_sc_first = w_ben & bus.sc & ~r_sc_q;
  assign w_wr       = w_ben & bus.wc & ~r_wc_q & (r_sel == SEL_DATA);
  assign w_rd       = w_ben & ~bus.sc & ~bus.wc & (r_sel != SEL_NONE);
  assign w_rd_first = w_rd & ~r_rd_q;
  assign w_tx_hs    = r_tx_valid & bus.tx_ready;
  assign w_rx_acc   = bus.rx_valid & bus.rx_ready;

  // Gate with reset so the bus is released in the very cycle reset is sampled.
  assign w_drive    = w_rd & reset;

  assign w_rd_byte  = (r_sel == SEL_DATA) ? r_rx_reg
                                          : {4'b0000, r_rx_unf, r_tx_ovr, r_tx_valid, r_rx_full};

  assign bus.iv_oeb   = ~w_drive;
  assign bus.iv_out   = w_drive ? f_conv(w_rd_byte) : 8'hFF;
  assign bus.tx_data  = r_tx_reg;
  assign bus.tx_valid = r_tx_valid;
  // Blocking accepts during a read window keeps rx_reg stable while the CPU
  // is stalled on it.
  assign bus.rx_ready = ~r_rx_full & ~w_rd;
  assign bus.selected = (r_sel != SEL_NONE);

  // Selection is sticky; only a fresh SC on this bank changes it.
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_sc_first) begin
      if (w_b == DATA_ADDR)      w_sel_nxt = SEL_DATA;
      else if (w_b == STAT_ADDR) w_sel_nxt = SEL_STAT;
      else                       w_sel_nxt = SEL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_sel <= SEL_NONE;
    else        r_sel <= w_sel_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sc_q     <= 1'b0;
      r_wc_q     <= 1'b0;
      r_rd_q     <= 1'b0;
      r_tx_reg   <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_ovr   <= 1'b0;
      r_rx_reg   <= 8'h00;
      r_rx_full  <= 1'b0;
      r_rx_unf   <= 1'b0;
    end else begin
      r_sc_q <= bus.sc;
      r_wc_q <= bus.wc;
      r_rd_q <= w_rd;

      // A CPU write wins over a simultaneous user handshake: the new byte is
      // loaded and stays valid, and that case is not an overrun.
      if (w_wr) begin
        r_tx_reg   <= w_b;
        r_tx_valid <= 1'b1;
        if (r_tx_valid && !w_tx_hs) r_tx_ovr <= 1'b1;
      end else if (w_tx_hs) begin
        r_tx_valid <= 1'b0;
      end

      // Accepts cannot coincide with a read window (rx_ready gated by rd),
      // so the set and clear of rx_full never collide.
      if (w_rx_acc) begin
        r_rx_reg  <= bus.rx_data;
        r_rx_full <= 1'b1;
      end

      if (w_rd_first && r_sel == SEL_DATA) begin
        if (r_rx_full) r_rx_full <= 1'b0;
        else           r_rx_unf  <= 1'b1;
      end

      if (w_rd_first && r_sel == SEL_STAT) begin
        r_rx_unf <= 1'b0;
        r_tx_ovr <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iv_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_iv_port_responder
// Description : Self-checking bench for iv_port_responder. Two instances:
//               dut0 on the left bank, dut1 on the right bank. Expected bus
//               read bytes and tx bytes are queued when stimulus is applied
//               and popped when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iv_port_responder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  iv_port_responder_if bus0();
  iv_port_responder_if bus1();

  iv_port_responder #(.BANK(0), .DATA_ADDR(8'h10), .STAT_ADDR(8'h11)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  iv_port_responder #(.BANK(1), .DATA_ADDR(8'h10), .STAT_ADDR(8'h11)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q_rd[$];
  logic [7:0] q_tx[$];
  logic [7:0] exp_b;

  // Bus encoding model: b[i] = !iv[7-i].
  function automatic logic [7:0] enc(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = ~b[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_set(input int u, input logic bk, input logic en,
                         input logic s, input logic w, input logic [7:0] b);
    if (u == 0) begin
      bus0.lb_n = !(en && !bk); bus0.rb_n = !(en && bk);
      bus0.sc = s; bus0.wc = w; bus0.iv_in = enc(b);
    end else begin
      bus1.lb_n = !(en && !bk); bus1.rb_n = !(en && bk);
      bus1.sc = s; bus1.wc = w; bus1.iv_in = enc(b);
    end
  endtask

  // Hold a command n cycles, then one idle cycle so the next command edges.
  task automatic cmd(input int u, input logic bk, input logic s, input logic w,
                     input logic [7:0] b, input int n);
    bus_set(u, bk, 1'b1, s, w, b);
    repeat (n) tick();
    bus_set(u, bk, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_set(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_set(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus0.tx_ready = 0; bus0.rx_valid = 0; bus0.rx_data = 8'h00;
    bus1.tx_ready = 0; bus1.rx_valid = 0; bus1.rx_data = 8'h00;
    tick(); tick();
    n_vec++; if (bus0.iv_oeb !== 1'b1) begin n_err++; $display("FAIL rst_oeb got %b want 1", bus0.iv_oeb); end
    n_vec++; if (bus0.iv_out !== 8'hFF) begin n_err++; $display("FAIL rst_out got %h want ff", bus0.iv_out); end
    n_vec++; if (bus0.tx_data !== 8'h00) begin n_err++; $display("FAIL rst_txd got %h want 00", bus0.tx_data); end
    n_vec++; if (bus0.tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_txv got %b want 0", bus0.tx_valid); end
    n_vec++; if (bus0.rx_ready !== 1'b1) begin n_err++; $display("FAIL rst_rxr got %b want 1", bus0.rx_ready); end
    n_vec++; if (bus0.selected !== 1'b0) begin n_err++; $display("FAIL rst_sel got %b want 0", bus0.selected); end
    n_vec++; if (bus1.iv_oeb !== 1'b1) begin n_err++; $display("FAIL rst_oeb1 got %b want 1", bus1.iv_oeb); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_select_write();
    cmd(0, 1'b0, 1'b1, 1'b0, 8'h10, 1);
    n_vec++; if (bus0.selected !== 1'b1) begin n_err++; $display("FAIL sel_data got %b want 1", bus0.selected); end
    q_tx.push_back(8'hA5);
    cmd(0, 1'b0, 1'b0, 1'b1, 8'hA5, 1);
    exp_b = q_tx.pop_front();
    n_vec++; if (bus0.tx_data !== exp_b) begin n_err++; $display("FAIL wr_txd got %h want %h", bus0.tx_data, exp_b); end
    n_vec++; if (bus0.tx_valid !== 1'b1) begin n_err++; $display("FAIL wr_txv got %b want 1", bus0.tx_valid); end
    bus0.tx_ready = 1'b1; tick(); bus0.tx_ready = 1'b0;
    n_vec++; if (bus0.tx_valid !== 1'b0) begin n_err++; $display("FAIL hs_txv got %b want 0", bus0.tx_valid); end
    // SC on the other bank must not disturb this selection.
    cmd(0, 1'b1, 1'b1, 1'b0, 8'h77, 1);
    n_vec++; if (bus0.selected !== 1'b1) begin n_err++; $display("FAIL other_bank_sel got %b want 1", bus0.selected); end
  endtask

  task automatic test_rx_read();
    bus0.rx_data = 8'h3C; bus0.rx_valid = 1'b1; #1;
    n_vec++; if (bus0.rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_rdy0 got %b want 1", bus0.rx_ready); end
    tick(); bus0.rx_valid = 1'b0; #1;
    n_vec++; if (bus0.rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_full_rdy got %b want 0", bus0.rx_ready); end
    q_rd.push_back(8'hC3);
    bus_set(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); #1;
    exp_b = q_rd.pop_front();
    n_vec++; if (bus0.iv_oeb !== 1'b0) begin n_err++; $display("FAIL rd_oeb got %b want 0", bus0.iv_oeb); end
    n_vec++; if (bus0.iv_out !== exp_b) begin n_err++; $display("FAIL rd_out got %h want %h", bus0.iv_out, exp_b); end
    tick();
    bus_set(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); #1;
    n_vec++; if (bus0.rx_ready !== 1'b1) begin n_err++; $display("FAIL rd_rxr got %b want 1", bus0.rx_ready); end
    n_vec++; if (bus0.iv_oeb !== 1'b1) begin n_err++; $display("FAIL rd_close_oeb got %b want 1", bus0.iv_oeb); end
    tick();
  endtask

  // Two reads on the current selection; expected bytes already queued.
  task automatic two_reads(input string nm);
    for (int k = 0; k < 2; k++) begin
      bus_set(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); #1;
      exp_b = q_rd.pop_front();
      n_vec++; if (bus0.iv_oeb !== 1'b0 || bus0.iv_out !== exp_b) begin
        n_err++; $display("FAIL %s_%0d got oeb=%b out=%h want oeb=0 out=%h", nm, k, bus0.iv_oeb, bus0.iv_out, exp_b);
      end
      tick();
      bus_set(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
    end
  endtask

  task automatic test_overrun();
    bus0.rx_data = 8'h5A; bus0.rx_valid = 1'b1; tick(); bus0.rx_valid = 1'b0;
    q_tx.push_back(8'h02);
    cmd(0, 1'b0, 1'b0, 1'b1, 8'h01, 1);
    cmd(0, 1'b0, 1'b0, 1'b1, 8'h02, 1);
    exp_b = q_tx.pop_front();
    n_vec++; if (bus0.tx_data !== exp_b) begin n_err++; $display("FAIL ovr_txd got %h want %h", bus0.tx_data, exp_b); end
    n_vec++; if (bus0.tx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_txv got %b want 1", bus0.tx_valid); end
    bus0.tx_ready = 1'b1; tick(); bus0.tx_ready = 1'b0;
    cmd(0, 1'b0, 1'b1, 1'b0, 8'h11, 1);
    q_rd.push_back(enc(8'h05));
    q_rd.push_back(enc(8'h01));
    two_reads("stat_ovr");
  endtask

  task automatic test_underflow();
    cmd(0, 1'b0, 1'b1, 1'b0, 8'h10, 1);
    q_rd.push_back(enc(8'h5A));
    q_rd.push_back(enc(8'h5A));
    two_reads("data_unf");
    cmd(0, 1'b0, 1'b1, 1'b0, 8'h11, 1);
    q_rd.push_back(enc(8'h08));
    q_rd.push_back(enc(8'h00));
    two_reads("stat_unf");
  endtask

  task automatic test_bank1();
    cmd(1, 1'b0, 1'b1, 1'b0, 8'h10, 1);
    n_vec++; if (bus1.selected !== 1'b0) begin n_err++; $display("FAIL b1_left_sc got %b want 0", bus1.selected); end
    cmd(1, 1'b1, 1'b1, 1'b0, 8'h10, 1);
    n_vec++; if (bus1.selected !== 1'b1) begin n_err++; $display("FAIL b1_right_sc got %b want 1", bus1.selected); end
    cmd(1, 1'b0, 1'b0, 1'b1, 8'h99, 1);
    n_vec++; if (bus1.tx_valid !== 1'b0) begin n_err++; $display("FAIL b1_left_wc got %b want 0", bus1.tx_valid); end
    bus_set(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); #1;
    n_vec++; if (bus1.iv_oeb !== 1'b1) begin n_err++; $display("FAIL b1_left_rd got %b want 1", bus1.iv_oeb); end
    tick(); bus_set(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    q_rd.push_back(enc(8'h00));
    bus_set(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); #1;
    exp_b = q_rd.pop_front();
    n_vec++; if (bus1.iv_oeb !== 1'b0 || bus1.iv_out !== exp_b) begin
      n_err++; $display("FAIL b1_right_rd got oeb=%b out=%h want oeb=0 out=%h", bus1.iv_oeb, bus1.iv_out, exp_b);
    end
    tick(); bus_set(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    cmd(1, 1'b1, 1'b1, 1'b0, 8'h77, 1);
    n_vec++; if (bus1.selected !== 1'b0) begin n_err++; $display("FAIL b1_desel got %b want 0", bus1.selected); end
    bus_set(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); #1;
    n_vec++; if (bus1.iv_oeb !== 1'b1) begin n_err++; $display("FAIL b1_desel_rd got %b want 1", bus1.iv_oeb); end
    tick(); bus_set(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
  endtask

  task automatic test_stall();
    bus0.rx_data = 8'h96; bus0.rx_valid = 1'b1; tick(); bus0.rx_valid = 1'b0;
    cmd(0, 1'b0, 1'b1, 1'b0, 8'h10, 3);
    n_vec++; if (bus0.selected !== 1'b1) begin n_err++; $display("FAIL st_sel got %b want 1", bus0.selected); end
    q_tx.push_back(8'h4E);
    cmd(0, 1'b0, 1'b0, 1'b1, 8'h4E, 3);
    exp_b = q_tx.pop_front();
    n_vec++; if (bus0.tx_data !== exp_b || bus0.tx_valid !== 1'b1) begin
      n_err++; $display("FAIL st_wr got %h/%b want %h/1", bus0.tx_data, bus0.tx_valid, exp_b);
    end
    bus0.rx_data = 8'h11; bus0.rx_valid = 1'b1;
    repeat (3) q_rd.push_back(enc(8'h96));
    bus_set(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_b = q_rd.pop_front();
      n_vec++; if (bus0.iv_oeb !== 1'b0 || bus0.iv_out !== exp_b || bus0.rx_ready !== 1'b0) begin
        n_err++; $display("FAIL st_win_%0d got oeb=%b out=%h rxr=%b want oeb=0 out=%h rxr=0",
                          k, bus0.iv_oeb, bus0.iv_out, bus0.rx_ready, exp_b);
      end
      tick();
    end
    bus0.rx_valid = 1'b0;
    bus_set(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    // One write (no overrun), one consume (rx empty, no underflow).
    cmd(0, 1'b0, 1'b1, 1'b0, 8'h11, 1);
    q_rd.push_back(enc(8'h02));
    bus_set(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); #1;
    exp_b = q_rd.pop_front();
    n_vec++; if (bus0.iv_out !== exp_b) begin n_err++; $display("FAIL st_stat got %h want %h", bus0.iv_out, exp_b); end
    tick(); bus_set(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    // Reset in the middle of a read window.
    cmd(0, 1'b0, 1'b1, 1'b0, 8'h10, 1);
    bus_set(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); #1;
    n_vec++; if (bus0.iv_oeb !== 1'b0) begin n_err++; $display("FAIL rstwin_pre got %b want 0", bus0.iv_oeb); end
    reset = 1'b0; #1;
    n_vec++; if (bus0.iv_oeb !== 1'b1 || bus0.iv_out !== 8'hFF) begin
      n_err++; $display("FAIL rstwin_drop got oeb=%b out=%h want oeb=1 out=ff", bus0.iv_oeb, bus0.iv_out);
    end
    tick();
    reset = 1'b1;
    bus_set(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); #1;
    n_vec++; if (bus0.selected !== 1'b0 || bus0.tx_valid !== 1'b0) begin
      n_err++; $display("FAIL rstwin_state got sel=%b txv=%b want 0/0", bus0.selected, bus0.tx_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_select_write();
    test_rx_read();
    test_overrun();
    test_underflow();
    test_bank1();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
